emotion_argmax: RTL and testbench
=================================

Name: emotion_argmax

Overview:
- Final classification stage, directly downstream of the fully-connected output layer.
- Consumes the FC result stream (one 32-bit score per data-ready strobe, NUM_CLASS scores per image).
- Tracks the running maximum and emits the winning class index and its score once per frame.
- Output drives the board-level result register and LED/UART reporting.

Parameters:
- BIT, 32, score width; IEEE-754 single precision.
- NUM_CLASS, 7, scores per frame (emotion classes).
- IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_CLASS.

Ports:
- clk  in  1  system clock.
- rst_  in  1  asynchronous active-low reset.
- data_in  in  BIT  FC score, valid when data_ready_in=1.
- data_ready_in  in  1  one-cycle strobe per score, any spacing, back-to-back allowed.
- clear  in  1  synchronous frame abort.
- class_out  out  IDX_W  winning class index.
- score_out  out  BIT  winning score (raw bits).
- class_valid  out  1  one-cycle pulse, results updated.
- busy  out  1  high while a frame is partially received.

Behaviour:
- Clock and reset: one clock, clk. rst_ is asynchronous and active-low.
- Reset values: class_out=0, score_out=0, class_valid=0, busy=0. Internal count=0, best_idx=0, best_key=0, state=IDLE.
- Compare key: key = data_in[31] ? ~data_in : {1'b1, data_in[30:0]}. Unsigned compare of keys gives total float order, so -0.0 ranks below +0.0. NaN is not expected; it is ordered by key with no special handling.
- Tie rule: a score replaces the best only if its key is strictly greater, so the lowest index wins ties.
- States:
  - IDLE: waiting for the first score.
  - ACCUM: count in 1..NUM_CLASS-1.
- IDLE plus strobe: best := sample, best_idx := 0, count := 1, go to ACCUM, busy=1 next cycle.
- ACCUM plus strobe:
  - Compare the sample against the best; update if greater; count++.
  - If this is the NUM_CLASS-th sample: register the final winner, including the current sample, into class_out/score_out; pulse class_valid the next cycle; count := 0; return to IDLE; busy=0.
- Latency: class_valid rises exactly 1 cycle after the last strobe of the frame.
- Back-to-back frames: a strobe in the cycle class_valid is high is accepted as index 0 of the next frame, with no bubble.
- Outputs class_out/score_out hold between frames and change only with class_valid.
- clear: the partial frame is discarded; state := IDLE, count := 0, busy := 0. Held outputs are untouched and no class_valid pulse is issued.
- clear together with data_ready_in in the same cycle: clear wins and the sample is dropped.
- clear together with the final sample: no result is produced.
- Reset mid-frame: everything returns immediately to reset values and the partial frame is lost.
- NUM_CLASS=1: every strobe produces class_valid with class_out=0.

Optional Feature:
- Macro: EMOTION_ARGMAX_TOP2_EN.
- When defined:
  - Adds outputs class2_out[IDX_W-1:0] and score2_out[BIT-1:0] (runner-up), both reset to 0.
  - A new maximum demotes the old best to runner-up.
  - Otherwise, a key strictly greater than the runner-up key replaces the runner-up.
  - The runner-up is published with class_valid.
  - NUM_CLASS=1 gives class2_out=0, score2_out=0.
- When not defined: the ports and logic are absent, and the core behaviour is identical.

Decomposition:
- Shared package holds:
  - FP32 constants: positive/negative zero, minus-infinity key.
  - Default NUM_CLASS=7.
  - The emotion class enumeration (angry, disgust, fear, happy, sad, surprise, neutral → 0..6).
- One natural sub-module: fp32_order_key, a combinational float-to-unsigned-key mapper reused by the compare path and the runner-up path.

Test Plan:
- Scores {1.0, 3.5, -2.0, 0.25, 3.0, 0.0, -7.0} (0x3F800000, 0x40600000, ...), one per cycle → class_valid 1 cycle after 7th strobe, class_out=1, score_out=0x40600000, busy low same cycle.
- All negative {-5,-1,-3,-0.5,-9,-2,-4} with gaps of 3 idle cycles between strobes → class_out=3, score_out=0xBF000000; busy high from cycle after first strobe until after last.
- Ties: {2.0, 2.0, ..., 2.0} → class_out=0. Mixed zeros {-0.0, +0.0, -0.0, ...} → class_out=1.
- Two frames back-to-back (14 consecutive strobes, winners at index 6 then index 2) → two class_valid pulses 7 cycles apart, class_out=6 then 2.
- clear asserted after 4 strobes, then a fresh full frame → no pulse for the aborted frame, result reflects only the new frame. clear coincident with the 7th strobe → no pulse and prior outputs held.
- rst_ dropped asynchronously mid-frame (between clock edges) → outputs zero immediately, next full frame yields correct result.
- With EMOTION_ARGMAX_TOP2_EN, frame 1 → class2_out=4, score2_out=0x40400000.

Source files
------------

// File: rtl/emotion_argmax_pkg.sv
// Shared constants and types for the emotion classifier argmax stage.
// Used by emotion_argmax (optional EMOTION_ARGMAX_TOP2_EN runner-up output) and fp32_order_key.
package emotion_argmax_pkg;

    localparam int unsigned FP32_W            = 32;
    localparam logic [31:0] FP32_POS_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP32_NEG_ZERO     = 32'h8000_0000;
    localparam logic [31:0] FP32_KEY_NEG_INF  = 32'h007F_FFFF;
    localparam logic [31:0] FP32_KEY_FLOOR    = 32'h0000_0000;
    localparam int unsigned DEFAULT_NUM_CLASS = 7;

    typedef enum logic [2:0] {
        EMO_ANGRY    = 3'd0,
        EMO_DISGUST  = 3'd1,
        EMO_FEAR     = 3'd2,
        EMO_HAPPY    = 3'd3,
        EMO_SAD      = 3'd4,
        EMO_SURPRISE = 3'd5,
        EMO_NEUTRAL  = 3'd6
    } emotion_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/emotion_argmax_fp32_order_key.sv
// Maps an IEEE-754 bit pattern to an unsigned key whose integer order is the float order.
// Negative values are fully inverted so -0.0 lands just below +0.0.
module fp32_order_key #(
    parameter int unsigned BIT = 32
) (
    input  logic [BIT-1:0] i_data,
    output logic [BIT-1:0] o_key
);

    assign o_key = i_data[BIT-1] ? ~i_data : {1'b1, i_data[BIT-2:0]};

endmodule

// File: rtl/emotion_argmax.sv
// Running argmax over NUM_CLASS FC scores per frame; publishes winner index and raw score.
// Define EMOTION_ARGMAX_TOP2_EN to also track and publish the runner-up on class2_out/score2_out.
module emotion_argmax
    import emotion_argmax_pkg::*;
#(
    parameter int unsigned BIT       = FP32_W,
    parameter int unsigned NUM_CLASS = DEFAULT_NUM_CLASS,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [BIT-1:0]   data_in,
    input  logic             data_ready_in,
    input  logic             clear,
    output logic [IDX_W-1:0] class_out,
    output logic [BIT-1:0]   score_out,
    output logic             class_valid,
    output logic             busy
`ifdef EMOTION_ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0] class2_out,
    output logic [BIT-1:0]   score2_out
`endif
);

    localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NUM_CLASS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(EMO_ANGRY);

    state_e           r_state,      w_state_nxt;
    logic [IDX_W-1:0] r_count,      w_count_nxt;
    logic [IDX_W-1:0] r_best_idx,   w_best_idx_nxt;
    logic [BIT-1:0]   r_best_key,   w_best_key_nxt;
    logic [BIT-1:0]   r_best_score, w_best_score_nxt;
    logic [IDX_W-1:0] r_class,      w_class_nxt;
    logic [BIT-1:0]   r_score,      w_score_nxt;
    logic             r_valid,      w_valid_nxt;
    logic [BIT-1:0]   w_sample_key;
    logic             w_publish;

    fp32_order_key #(.BIT(BIT)) u_sample_key (
        .i_data (data_in),
        .o_key  (w_sample_key)
    );

`ifdef EMOTION_ARGMAX_TOP2_EN
    logic [IDX_W-1:0] r_sec_idx,   w_sec_idx_nxt;
    logic [BIT-1:0]   r_sec_key,   w_sec_key_nxt;
    logic [BIT-1:0]   r_sec_score, w_sec_score_nxt;
    logic [IDX_W-1:0] r_class2,    w_class2_nxt;
    logic [BIT-1:0]   r_score2,    w_score2_nxt;
`endif

    always_comb begin
        // NOTE: every combinational output gets its hold value first so no branch can infer a latch.
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_best_idx_nxt   = r_best_idx;
        w_best_key_nxt   = r_best_key;
        w_best_score_nxt = r_best_score;
        w_publish        = 1'b0;
`ifdef EMOTION_ARGMAX_TOP2_EN
        w_sec_idx_nxt    = r_sec_idx;
        w_sec_key_nxt    = r_sec_key;
        w_sec_score_nxt  = r_sec_score;
`endif
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else if (data_ready_in) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_best_idx_nxt   = FIRST_IDX;
                    w_best_key_nxt   = w_sample_key;
                    w_best_score_nxt = data_in;
`ifdef EMOTION_ARGMAX_TOP2_EN
                    // Floor key sits below every real score so the first later sample always claims runner-up.
                    w_sec_idx_nxt    = '0;
                    w_sec_key_nxt    = BIT'(FP32_KEY_FLOOR);
                    w_sec_score_nxt  = BIT'(FP32_POS_ZERO);
`endif
                    if (NUM_CLASS == 1) begin
                        w_publish   = 1'b1;
                        w_count_nxt = '0;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_count_nxt = IDX_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (w_sample_key > r_best_key) begin
                        w_best_idx_nxt   = r_count;
                        w_best_key_nxt   = w_sample_key;
                        w_best_score_nxt = data_in;
`ifdef EMOTION_ARGMAX_TOP2_EN
                        w_sec_idx_nxt    = r_best_idx;
                        w_sec_key_nxt    = r_best_key;
                        w_sec_score_nxt  = r_best_score;
                    end else if (w_sample_key > r_sec_key) begin
                        w_sec_idx_nxt    = r_count;
                        w_sec_key_nxt    = w_sample_key;
                        w_sec_score_nxt  = data_in;
`endif
                    end
                    if (r_count == LAST_CNT) begin
                        w_publish   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + IDX_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign w_valid_nxt = w_publish;
    assign w_class_nxt = w_publish ? w_best_idx_nxt   : r_class;
    assign w_score_nxt = w_publish ? w_best_score_nxt : r_score;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_best_idx   <= '0;
            r_best_key   <= '0;
            r_best_score <= '0;
            r_class      <= '0;
            r_score      <= '0;
            r_valid      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_best_idx   <= w_best_idx_nxt;
            r_best_key   <= w_best_key_nxt;
            r_best_score <= w_best_score_nxt;
            r_class      <= w_class_nxt;
            r_score      <= w_score_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    assign class_out   = r_class;
    assign score_out   = r_score;
    assign class_valid = r_valid;
    assign busy        = (r_state == ST_ACCUM);

`ifdef EMOTION_ARGMAX_TOP2_EN
    assign w_class2_nxt = w_publish ? w_sec_idx_nxt   : r_class2;
    assign w_score2_nxt = w_publish ? w_sec_score_nxt : r_score2;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sec_idx   <= '0;
            r_sec_key   <= '0;
            r_sec_score <= '0;
            r_class2    <= '0;
            r_score2    <= '0;
        end else begin
            r_sec_idx   <= w_sec_idx_nxt;
            r_sec_key   <= w_sec_key_nxt;
            r_sec_score <= w_sec_score_nxt;
            r_class2    <= w_class2_nxt;
            r_score2    <= w_score2_nxt;
        end
    end

    assign class2_out = r_class2;
    assign score2_out = r_score2;
`endif

endmodule

// File: tb/tb_emotion_argmax.sv
// Directed-vector bench for emotion_argmax (7-class main instance plus a NUM_CLASS=1 instance).
module tb_emotion_argmax;

    logic        clk;
    logic        rst_;
    logic [31:0] data_in;
    logic        data_ready_in;
    logic        clear;

    logic [2:0]  class_out;
    logic [31:0] score_out;
    logic        class_valid;
    logic        busy;

    logic [0:0]  class_out1;
    logic [31:0] score_out1;
    logic        class_valid1;
    logic        busy1;

`ifdef EMOTION_ARGMAX_TOP2_EN
    logic [2:0]  class2_out;
    logic [31:0] score2_out;
    logic [0:0]  class2_out1;
    logic [31:0] score2_out1;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int pulses  = 0;
    int pulses1 = 0;

    logic [31:0] f_main [7] = '{32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h3E80_0000,
                                32'h4040_0000, 32'h0000_0000, 32'hC0E0_0000};
    logic [31:0] f_neg  [7] = '{32'hC0A0_0000, 32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000,
                                32'hC110_0000, 32'hC000_0000, 32'hC080_0000};
    logic [31:0] f_tie  [7] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                                32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    logic [31:0] f_zero [7] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] f_b2b [14] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000,
                                32'hC000_0000, 32'h3E80_0000, 32'h4100_0000,
                                32'h3F80_0000, 32'hBF80_0000, 32'h4120_0000, 32'h4000_0000,
                                32'h4040_0000, 32'h0000_0000, 32'h40E0_0000};

    emotion_argmax #(.BIT(32), .NUM_CLASS(7), .IDX_W(3)) u_dut (
        .clk           (clk),
        .rst_          (rst_),
        .data_in       (data_in),
        .data_ready_in (data_ready_in),
        .clear         (clear),
        .class_out     (class_out),
        .score_out     (score_out),
        .class_valid   (class_valid),
        .busy          (busy)
`ifdef EMOTION_ARGMAX_TOP2_EN
        ,
        .class2_out    (class2_out),
        .score2_out    (score2_out)
`endif
    );

    emotion_argmax #(.BIT(32), .NUM_CLASS(1), .IDX_W(1)) u_dut1 (
        .clk           (clk),
        .rst_          (rst_),
        .data_in       (data_in),
        .data_ready_in (data_ready_in),
        .clear         (clear),
        .class_out     (class_out1),
        .score_out     (score_out1),
        .class_valid   (class_valid1),
        .busy          (busy1)
`ifdef EMOTION_ARGMAX_TOP2_EN
        ,
        .class2_out    (class2_out1),
        .score2_out    (score2_out1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (class_valid)  pulses++;
        if (class_valid1) pulses1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one 7-score frame with `gap` idle cycles between strobes, then checks the result pulse.
    task automatic run_frame(input logic [31:0] v [7], input int gap, input logic [2:0] exp_cls,
                             input logic [31:0] exp_score, input string tag);
        int p0;
        p0 = pulses;
        for (int i = 0; i < 7; i++) begin
            data_in       = v[i];
            data_ready_in = 1'b1;
            tick();
            data_ready_in = 1'b0;
            if (i < 6) begin
                for (int g = 0; g < gap; g++) tick();
                check({tag, "_busy_mid"}, 32'(busy), 32'd1);
            end
        end
        check({tag, "_valid"}, 32'(class_valid), 32'd1);
        check({tag, "_class"}, 32'(class_out), 32'(exp_cls));
        check({tag, "_score"}, score_out, exp_score);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_valid_drop"}, 32'(class_valid), 32'd0);
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        rst_          = 1'b0;
        data_in       = '0;
        data_ready_in = 1'b0;
        clear         = 1'b0;
        #12;
        check("rst_class", 32'(class_out), 32'd0);
        check("rst_score", score_out, 32'h0);
        check("rst_valid", 32'(class_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        rst_ = 1'b1;
        tick();

        // Mixed-sign frame, strobes back-to-back.
        run_frame(f_main, 0, 3'd1, 32'h4060_0000, "f1");
`ifdef EMOTION_ARGMAX_TOP2_EN
        check("f1_class2", 32'(class2_out), 32'd4);
        check("f1_score2", score2_out, 32'h4040_0000);
        check("n1_class2", 32'(class2_out1), 32'd0);
        check("n1_score2", score2_out1, 32'h0);
`endif
        check("n1_pulses", 32'(pulses1), 32'd7);
        check("n1_class",  32'(class_out1), 32'd0);
        check("n1_score",  score_out1, 32'hC0E0_0000);

        // All-negative frame with 3 idle cycles between strobes.
        run_frame(f_neg, 3, 3'd3, 32'hBF00_0000, "neg");
`ifdef EMOTION_ARGMAX_TOP2_EN
        check("neg_class2", 32'(class2_out), 32'd1);
        check("neg_score2", score2_out, 32'hBF80_0000);
`endif

        run_frame(f_tie,  0, 3'd0, 32'h4000_0000, "tie");
        run_frame(f_zero, 1, 3'd1, 32'h0000_0000, "zero");

        // Two frames with no bubble between them.
        for (int i = 0; i < 14; i++) begin
            data_in       = f_b2b[i];
            data_ready_in = 1'b1;
            tick();
            if (i == 6) begin
                check("b2b_a_valid", 32'(class_valid), 32'd1);
                check("b2b_a_class", 32'(class_out), 32'd6);
                check("b2b_a_score", score_out, 32'h4100_0000);
            end
            if (i == 7) begin
                check("b2b_gap_valid", 32'(class_valid), 32'd0);
                check("b2b_hold_class", 32'(class_out), 32'd6);
            end
            if (i == 12) check("b2b_pre_valid", 32'(class_valid), 32'd0);
        end
        data_ready_in = 1'b0;
        check("b2b_b_valid", 32'(class_valid), 32'd1);
        check("b2b_b_class", 32'(class_out), 32'd2);
        check("b2b_b_score", score_out, 32'h4120_0000);
        tick();

        // Abort after 4 strobes, then a full frame.
        for (int i = 0; i < 4; i++) begin
            data_in       = f_main[i];
            data_ready_in = 1'b1;
            tick();
        end
        data_ready_in = 1'b0;
        clear         = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy",  32'(busy), 32'd0);
        check("clr_valid", 32'(class_valid), 32'd0);
        check("clr_hold_class", 32'(class_out), 32'd2);
        check("clr_hold_score", score_out, 32'h4120_0000);
        run_frame(f_neg, 0, 3'd3, 32'hBF00_0000, "post_clr");

        // clear coincident with the final strobe.
        for (int i = 0; i < 6; i++) begin
            data_in       = f_main[i];
            data_ready_in = 1'b1;
            tick();
        end
        data_in = f_main[6];
        clear   = 1'b1;
        tick();
        data_ready_in = 1'b0;
        clear         = 1'b0;
        check("clr7_valid", 32'(class_valid), 32'd0);
        check("clr7_class", 32'(class_out), 32'd3);
        check("clr7_score", score_out, 32'hBF00_0000);
        check("clr7_busy",  32'(busy), 32'd0);
        tick();
        check("clr7_valid_late", 32'(class_valid), 32'd0);

        // Asynchronous reset between clock edges mid-frame.
        for (int i = 0; i < 3; i++) begin
            data_in       = f_tie[i];
            data_ready_in = 1'b1;
            tick();
        end
        data_ready_in = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        check("arst_class", 32'(class_out), 32'd0);
        check("arst_score", score_out, 32'h0);
        check("arst_busy",  32'(busy), 32'd0);
        #1;
        rst_ = 1'b1;
        tick();
        run_frame(f_main, 0, 3'd1, 32'h4060_0000, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
